// File: rtl/iram_isa_pkg.sv
// ISA constants shared by the fetch sequencer and its decoder: opcodes,
// bus select codes, instruction field positions and sequencer states.
package iram_isa_pkg;

    localparam logic [5:0] OP_ADD          = 6'd1;
    localparam logic [5:0] OP_SUB          = 6'd2;
    localparam logic [5:0] OP_AND          = 6'd3;
    localparam logic [5:0] OP_OR           = 6'd4;
    localparam logic [5:0] OP_XOR          = 6'd5;
    localparam logic [5:0] OP_NOT          = 6'd6;
    localparam logic [5:0] OP_SHL          = 6'd7;
    localparam logic [5:0] OP_SHR          = 6'd8;
    localparam logic [5:0] OP_INC          = 6'd9;
    localparam logic [5:0] OP_CONSTANT2REG = 6'd10;
    localparam logic [5:0] OP_MERGE        = 6'd11;
    localparam logic [5:0] OP_MEM_WRITE    = 6'd12;
    localparam logic [5:0] OP_MEM_READ     = 6'd13;
    localparam logic [5:0] OP_JUMPZ        = 6'd14;
    localparam logic [5:0] OP_NJUMPZ       = 6'd15;
    localparam logic [5:0] OP_OVER         = 6'd16;

    localparam logic [2:0] SEL_PC = 3'd1;
    localparam logic [2:0] SEL_DR = 3'd2;
    localparam logic [2:0] SEL_R1 = 3'd3;
    localparam logic [2:0] SEL_R2 = 3'd4;
    localparam logic [2:0] SEL_R3 = 3'd5;
    localparam logic [2:0] SEL_R4 = 3'd6;
    localparam logic [2:0] SEL_R5 = 3'd7;

    localparam logic [3:0] C_NO_DEST = 4'd0;
    localparam logic [3:0] C_PC      = 4'd1;
    localparam logic [3:0] C_DR      = 4'd2;
    localparam logic [3:0] C_R1      = 4'd3;
    localparam logic [3:0] C_R2      = 4'd4;
    localparam logic [3:0] C_R3      = 4'd5;
    localparam logic [3:0] C_R4      = 4'd6;
    localparam logic [3:0] C_R5      = 4'd7;
    localparam logic [3:0] C_TR      = 4'd8;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 10;
    localparam int A_MSB  = 9;
    localparam int A_LSB  = 7;
    localparam int B_MSB  = 6;
    localparam int B_LSB  = 4;
    localparam int C_MSB  = 3;
    localparam int C_LSB  = 0;
    // CONSTANT2REG carries its destination in the A/B area instead
    localparam int K_MSB  = 9;
    localparam int K_LSB  = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_IMM,
        S_ISSUE,
        S_BRANCH,
        S_HALT
    } seq_state_t;

    function automatic logic is_two_word(input logic [5:0] op);
        return (op == OP_CONSTANT2REG) || (op == OP_JUMPZ) || (op == OP_NJUMPZ);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational field decode of one 16-bit instruction word.
module instr_decode
    import iram_isa_pkg::*;
(
    input  logic [15:0] word,
    output logic [5:0]  opcode,
    output logic [2:0]  a_sel,
    output logic [2:0]  b_sel,
    output logic [3:0]  c_sel,
    output logic        two_word,
    output logic        is_over,
    output logic        is_illegal
);

    always_comb begin
        opcode     = word[OP_MSB:OP_LSB];
        a_sel      = word[A_MSB:A_LSB];
        b_sel      = word[B_MSB:B_LSB];
        c_sel      = (opcode == OP_CONSTANT2REG) ? word[K_MSB:K_LSB] : word[C_MSB:C_LSB];
        two_word   = is_two_word(opcode);
        is_over    = (opcode == OP_OVER);
        is_illegal = (opcode == 6'd0) || (opcode > OP_OVER);
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch/decode sequencer: walks the instruction ROM, assembles one/two-word
// instructions, resolves branches and issues the rest over valid/ready.
// Optional ILLEGAL_TRAP_EN: illegal opcodes / out-of-range targets halt with illegal_err.
module instr_fetch_sequencer
    import iram_isa_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int IRAM_DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       iram_word,
    output logic [ADDR_W-1:0] iram_addr,
    input  logic              z_flag,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [5:0]        opcode,
    output logic [2:0]        a_sel,
    output logic [2:0]        b_sel,
    output logic [3:0]        c_sel,
    output logic [15:0]       imm,
    output logic              imm_valid,
    output logic              halted
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic              illegal_err
`endif
);

    localparam logic [ADDR_W-1:0] PC_LAST   = ADDR_W'(IRAM_DEPTH - 1);
    localparam logic [16:0]       DEPTH_EXT = 17'(IRAM_DEPTH);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
    logic [15:0]       ir, imm_q;
    logic              ir_load, imm_load;
    logic              branch_taken, target_oor;

    logic [5:0] fd_opcode;
    logic [2:0] fd_a_sel, fd_b_sel;
    logic [3:0] fd_c_sel;
    logic       fd_two_word, fd_is_over, fd_is_illegal;
    logic       id_two_word, id_is_over, id_is_illegal;

    // Fetch-side decode steers the FSM; issue-side decode drives the outputs
    instr_decode u_fetch_dec (
        .word       (iram_word),
        .opcode     (fd_opcode),
        .a_sel      (fd_a_sel),
        .b_sel      (fd_b_sel),
        .c_sel      (fd_c_sel),
        .two_word   (fd_two_word),
        .is_over    (fd_is_over),
        .is_illegal (fd_is_illegal)
    );

    instr_decode u_issue_dec (
        .word       (ir),
        .opcode     (opcode),
        .a_sel      (a_sel),
        .b_sel      (b_sel),
        .c_sel      (c_sel),
        .two_word   (id_two_word),
        .is_over    (id_is_over),
        .is_illegal (id_is_illegal)
    );

    logic unused_dec;
    assign unused_dec = ^{fd_opcode, fd_a_sel, fd_b_sel, fd_c_sel,
                          id_two_word, id_is_over, id_is_illegal};

    assign pc_inc       = (pc == PC_LAST) ? '0 : pc + ADDR_W'(1);
    assign branch_taken = ((opcode == OP_JUMPZ)  &&  z_flag) ||
                          ((opcode == OP_NJUMPZ) && !z_flag);
    assign target_oor   = {1'b0, imm_q} >= DEPTH_EXT;

`ifdef ILLEGAL_TRAP_EN
    logic err_set, err_clr;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_load   = 1'b0;
        imm_load  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        err_set   = 1'b0;
        err_clr   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                end
            end
            S_FETCH: begin
                ir_load = 1'b1;
                pc_nxt  = pc_inc;
                if (fd_two_word)      state_nxt = S_IMM;
                else if (fd_is_over)  state_nxt = S_HALT;
                else if (fd_is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_nxt = S_HALT;
                    err_set   = 1'b1;
`else
                    state_nxt = S_FETCH;
`endif
                end
                else                  state_nxt = S_ISSUE;
            end
            S_IMM: begin
                imm_load  = 1'b1;
                pc_nxt    = pc_inc;
                state_nxt = (opcode == OP_CONSTANT2REG) ? S_ISSUE : S_BRANCH;
            end
            S_ISSUE: begin
                if (issue_ready) state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                state_nxt = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
                if (target_oor) begin
                    state_nxt = S_HALT;
                    err_set   = 1'b1;
                end
                else if (branch_taken) pc_nxt = ADDR_W'(imm_q);
`else
                // An unreachable target degrades to fall-through
                if (branch_taken && !target_oor) pc_nxt = ADDR_W'(imm_q);
`endif
            end
            S_HALT: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
`ifdef ILLEGAL_TRAP_EN
                    err_clr   = 1'b1;
`endif
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            imm_q <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (ir_load)  ir    <= iram_word;
            if (imm_load) imm_q <= iram_word;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       illegal_err <= 1'b0;
        else if (err_clr) illegal_err <= 1'b0;
        else if (err_set) illegal_err <= 1'b1;
    end
`endif

    assign iram_addr   = pc;
    assign imm         = imm_q;
    assign issue_valid = (state == S_ISSUE);
    assign imm_valid   = issue_valid && (opcode == OP_CONSTANT2REG);
    assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed plan scenarios plus random programs
// checked against an instruction-level interpreter of the ROM contents.
module tb_instr_fetch_sequencer;

    localparam int DEPTH = 512;
    localparam logic [15:0] W_OVER = {6'd16, 10'd0};

    typedef struct packed {
        logic [5:0]  op;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [3:0]  c;
        logic [15:0] imm;
        logic        iv;
    } iss_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        z_flag = 1'b0;
    logic        issue_ready = 1'b0;
    logic [15:0] iram_word;
    logic [15:0] iram_addr;
    logic        issue_valid;
    logic [5:0]  opcode;
    logic [2:0]  a_sel, b_sel;
    logic [3:0]  c_sel;
    logic [15:0] imm;
    logic        imm_valid;
    logic        halted;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_err;
`endif

    logic [15:0] rom [DEPTH];
    iss_t        obs_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign iram_word = (iram_addr < 16'(DEPTH)) ? rom[iram_addr[8:0]] : 16'h0000;

    instr_fetch_sequencer #(.ADDR_W(16), .IRAM_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .iram_word   (iram_word),
        .iram_addr   (iram_addr),
        .z_flag      (z_flag),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .opcode      (opcode),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .c_sel       (c_sel),
        .imm         (imm),
        .imm_valid   (imm_valid),
        .halted      (halted)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_err (illegal_err)
`endif
    );

    always @(negedge clk)
        if (issue_valid && issue_ready)
            obs_q.push_back('{op: opcode, a: a_sel, b: b_sel, c: c_sel, imm: imm, iv: imm_valid});

    function automatic logic [15:0] alu(input logic [5:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [3:0] c);
        return {op, a, b, c};
    endfunction

    task automatic fill_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = W_OVER;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_to_halt(input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (halted) begin ok = 1'b1; break; end
            if (rnd) issue_ready = 1'($urandom_range(0, 1));
        end
        issue_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({issue_valid, halted, imm_valid, iram_addr, opcode, a_sel, b_sel, c_sel, imm} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b h=%0b iv=%0b addr=%0d op=%0d imm=%0d, want all 0",
                     issue_valid, halted, imm_valid, iram_addr, opcode, imm);
        end
`ifdef ILLEGAL_TRAP_EN
        n_checks++;
        if (illegal_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_illegal_err: got %0b want 0", illegal_err);
        end
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (issue_valid !== 1'b0 || halted !== 1'b0 || iram_addr !== 16'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got v=%0b h=%0b addr=%0d want 0 0 0", issue_valid, halted, iram_addr);
        end
    endtask

    task automatic test_basic_program();
        bit ok;
        fill_rom();
        rom[0] = {6'd10, 4'd3, 6'h2A};
        rom[1] = 16'd1235;
        rom[2] = alu(6'd1, 3'd3, 3'd5, 4'd2);
        rom[3] = {6'd16, 10'h155};
        obs_q.delete();
        issue_ready = 1'b1;
        do_start();
        run_to_halt(100, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_halt_timeout: halted=%0b want 1", halted); end
        n_checks++;
        if (obs_q.size() != 2) begin
            n_fail++; $display("FAIL basic_issue_count: got %0d want 2", obs_q.size());
        end else begin
            n_checks++;
            if (obs_q[0].op !== 6'd10 || obs_q[0].c !== 4'd3 || obs_q[0].imm !== 16'd1235 || obs_q[0].iv !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_issue1: got op=%0d c=%0d imm=%0d iv=%0b want 10 3 1235 1",
                         obs_q[0].op, obs_q[0].c, obs_q[0].imm, obs_q[0].iv);
            end
            n_checks++;
            if (obs_q[1].op !== 6'd1 || obs_q[1].a !== 3'd3 || obs_q[1].b !== 3'd5 ||
                obs_q[1].c !== 4'd2 || obs_q[1].iv !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_issue2: got op=%0d a=%0d b=%0d c=%0d iv=%0b want 1 3 5 2 0",
                         obs_q[1].op, obs_q[1].a, obs_q[1].b, obs_q[1].c, obs_q[1].iv);
            end
        end
        n_checks++;
        if (halted !== 1'b1 || iram_addr !== 16'd4) begin
            n_fail++; $display("FAIL basic_halt_pc: got h=%0b addr=%0d want 1 4", halted, iram_addr);
        end
    endtask

    task automatic test_branch();
        bit ok;
        for (int k = 0; k < 4; k++) begin
            logic [5:0] op;
            bit taken;
            int want;
            op = (k < 2) ? 6'd14 : 6'd15;
            z_flag = 1'(k % 2);
            taken = (op == 6'd14) ? (z_flag == 1'b1) : (z_flag == 1'b0);
            want = taken ? 21 : 8;
            fill_rom();
            for (int i = 0; i < 5; i++) rom[i] = alu(6'd1, 3'd1, 3'd2, 4'd3);
            rom[5] = {op, 10'd0};
            rom[6] = 16'd20;
            obs_q.delete();
            issue_ready = 1'b1;
            do_start();
            run_to_halt(200, 1'b0, ok);
            n_checks++;
            if (!ok || iram_addr !== 16'(want) || obs_q.size() != 5) begin
                n_fail++;
                $display("FAIL branch_op%0d_z%0b: got halted=%0b addr=%0d issues=%0d want 1 %0d 5",
                         op, z_flag, halted, iram_addr, obs_q.size(), want);
            end
        end
        z_flag = 1'b0;
    endtask

    task automatic test_back_pressure();
        bit ok;
        int waited;
        fill_rom();
        rom[0] = alu(6'd1, 3'd3, 3'd4, 4'd5);
        obs_q.delete();
        issue_ready = 1'b0;
        do_start();
        waited = 0;
        while (issue_valid !== 1'b1 && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        n_checks++;
        if (waited != 1) begin
            n_fail++; $display("FAIL bp_first_issue_latency: got %0d cycles want 1", waited);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (issue_valid !== 1'b1 || opcode !== 6'd1 || a_sel !== 3'd3 || b_sel !== 3'd4 ||
                c_sel !== 4'd5 || iram_addr !== 16'd1) begin
                n_fail++;
                $display("FAIL bp_hold_cycle%0d: got v=%0b op=%0d a=%0d b=%0d c=%0d addr=%0d want 1 1 3 4 5 1",
                         i, issue_valid, opcode, a_sel, b_sel, c_sel, iram_addr);
            end
            @(posedge clk); #1;
        end
        issue_ready = 1'b1;
        run_to_halt(50, 1'b0, ok);
        n_checks++;
        if (!ok || obs_q.size() != 1 || iram_addr !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_single_handshake: got halted=%0b issues=%0d addr=%0d want 1 1 2",
                     halted, obs_q.size(), iram_addr);
        end
    endtask

    task automatic test_pc_wrap();
        bit ok;
        int n;
        fill_rom();
        rom[0]   = {6'd14, 10'd0};
        rom[1]   = 16'd511;
        rom[2]   = alu(6'd2, 3'd1, 3'd1, 4'd1);
        rom[511] = alu(6'd11, 3'd6, 3'd7, 4'd8);
        z_flag = 1'b1;
        obs_q.delete();
        issue_ready = 1'b1;
        do_start();
        n = 0;
        while (iram_addr !== 16'd511 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        rom[0] = W_OVER;
        run_to_halt(50, 1'b0, ok);
        n_checks++;
        if (!ok || obs_q.size() != 1 || iram_addr !== 16'd1) begin
            n_fail++;
            $display("FAIL pc_wrap: got halted=%0b issues=%0d addr=%0d want 1 1 1",
                     halted, obs_q.size(), iram_addr);
        end else begin
            n_checks++;
            if (obs_q[0].op !== 6'd11 || obs_q[0].c !== 4'd8) begin
                n_fail++; $display("FAIL pc_wrap_issue: got op=%0d c=%0d want 11 8", obs_q[0].op, obs_q[0].c);
            end
        end
        z_flag = 1'b0;
    endtask

    task automatic test_illegal();
        bit ok;
        fill_rom();
        rom[0] = alu(6'd1, 3'd1, 3'd2, 4'd3);
        rom[1] = alu(6'd3, 3'd4, 3'd5, 4'd6);
        rom[2] = 16'h0123;
        obs_q.delete();
        issue_ready = 1'b1;
        do_start();
        run_to_halt(50, 1'b0, ok);
`ifdef ILLEGAL_TRAP_EN
        n_checks++;
        if (!ok || obs_q.size() != 2 || iram_addr !== 16'd3 || illegal_err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_trap: got halted=%0b issues=%0d addr=%0d err=%0b want 1 2 3 1",
                     halted, obs_q.size(), iram_addr, illegal_err);
        end
`else
        n_checks++;
        if (!ok || obs_q.size() != 2 || iram_addr !== 16'd4) begin
            n_fail++;
            $display("FAIL illegal_skip: got halted=%0b issues=%0d addr=%0d want 1 2 4",
                     halted, obs_q.size(), iram_addr);
        end
`endif
        do_start();
        n_checks++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL illegal_restart_halted: got %0b want 0", halted); end
`ifdef ILLEGAL_TRAP_EN
        n_checks++;
        if (illegal_err !== 1'b0) begin n_fail++; $display("FAIL illegal_restart_err: got %0b want 0", illegal_err); end
`endif
        run_to_halt(50, 1'b0, ok);
    endtask

    task automatic test_reset_mid_issue();
        bit ok;
        int n;
        fill_rom();
        rom[0] = alu(6'd2, 3'd5, 3'd6, 4'd7);
        issue_ready = 1'b0;
        do_start();
        n = 0;
        while (issue_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (issue_valid !== 1'b0 || iram_addr !== 16'd0 || halted !== 1'b0 || opcode !== 6'd0) begin
            n_fail++;
            $display("FAIL rst_mid_issue: got v=%0b addr=%0d h=%0b op=%0d want 0 0 0 0",
                     issue_valid, iram_addr, halted, opcode);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        obs_q.delete();
        issue_ready = 1'b1;
        do_start();
        n_checks++;
        if (iram_addr !== 16'd0 || issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_refetch_addr: got addr=%0d v=%0b want 0 0", iram_addr, issue_valid);
        end
        run_to_halt(50, 1'b0, ok);
        n_checks++;
        if (!ok || obs_q.size() != 1 || iram_addr !== 16'd2) begin
            n_fail++;
            $display("FAIL rst_refetch_run: got halted=%0b issues=%0d addr=%0d want 1 1 2",
                     halted, obs_q.size(), iram_addr);
        end else begin
            n_checks++;
            if (obs_q[0].op !== 6'd2 || obs_q[0].a !== 3'd5 || obs_q[0].b !== 3'd6 || obs_q[0].c !== 4'd7) begin
                n_fail++; $display("FAIL rst_refetch_issue: got op=%0d want 2", obs_q[0].op);
            end
        end
    endtask

    task automatic test_random_programs();
        for (int run = 0; run < 25; run++) begin
            int kind[12];
            int addr[13];
            int nins, p, mpc, steps;
            bit ok, mhalt, merr, z, taken;
            logic [15:0] w, im;
            logic [5:0] op;
            iss_t exp_q[$];

            fill_rom();
            nins = $urandom_range(3, 12);
            p = 0;
            for (int i = 0; i < nins; i++) begin
                kind[i] = $urandom_range(0, 9);
                addr[i] = p;
                p += (kind[i] >= 5 && kind[i] <= 8) ? 2 : 1;
            end
            addr[nins] = p;
            for (int i = 0; i < nins; i++) begin
                int a;
                a = addr[i];
                if (kind[i] <= 4) begin
                    op = 6'($urandom_range(1, 12));
                    if (op >= 6'd10) op = op + 6'd1;
                    rom[a] = {op, 10'($urandom)};
                end else if (kind[i] <= 6) begin
                    rom[a] = {6'd10, 10'($urandom)};
                    rom[a+1] = 16'($urandom);
                end else if (kind[i] <= 8) begin
                    rom[a] = {($urandom_range(0, 1) == 1) ? 6'd14 : 6'd15, 10'($urandom)};
                    if ($urandom_range(0, 5) == 0) rom[a+1] = 16'($urandom_range(DEPTH, 65535));
                    else rom[a+1] = 16'(addr[$urandom_range(i + 1, nins)]);
                end else begin
                    op = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(17, 63));
                    rom[a] = {op, 10'($urandom)};
                end
            end
            z = 1'($urandom_range(0, 1));

            mpc = 0; mhalt = 0; merr = 0; steps = 0;
            while (!mhalt && steps < 4000) begin
                steps++;
                w = rom[mpc];
                op = w[15:10];
                mpc = (mpc + 1) % DEPTH;
                if (op == 6'd16) mhalt = 1;
                else if (op == 6'd0 || op > 6'd16) begin
`ifdef ILLEGAL_TRAP_EN
                    mhalt = 1; merr = 1;
`endif
                end else if (op == 6'd10 || op == 6'd14 || op == 6'd15) begin
                    im = rom[mpc];
                    mpc = (mpc + 1) % DEPTH;
                    if (op == 6'd10)
                        exp_q.push_back('{op: op, a: w[9:7], b: w[6:4], c: w[9:6], imm: im, iv: 1'b1});
                    else begin
                        taken = (op == 6'd14) ? z : !z;
`ifdef ILLEGAL_TRAP_EN
                        if (int'(im) >= DEPTH) begin mhalt = 1; merr = 1; end
                        else if (taken) mpc = int'(im);
`else
                        if (taken && int'(im) < DEPTH) mpc = int'(im);
`endif
                    end
                end else
                    exp_q.push_back('{op: op, a: w[9:7], b: w[6:4], c: w[3:0], imm: 16'h0, iv: 1'b0});
            end

            z_flag = z;
            obs_q.delete();
            issue_ready = 1'b1;
            do_start();
            run_to_halt(3000, 1'b1, ok);
            n_checks++;
            if (!ok || iram_addr !== 16'(mpc) || obs_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_end: got halted=%0b addr=%0d issues=%0d want 1 %0d %0d",
                         run, halted, iram_addr, obs_q.size(), mpc, exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_checks++;
                    if (obs_q[i].op !== exp_q[i].op || obs_q[i].c !== exp_q[i].c || obs_q[i].iv !== exp_q[i].iv ||
                        (exp_q[i].iv && obs_q[i].imm !== exp_q[i].imm) ||
                        (!exp_q[i].iv && (obs_q[i].a !== exp_q[i].a || obs_q[i].b !== exp_q[i].b))) begin
                        n_fail++;
                        $display("FAIL rand%0d_issue%0d: got op=%0d a=%0d b=%0d c=%0d imm=%0d iv=%0b want op=%0d a=%0d b=%0d c=%0d imm=%0d iv=%0b",
                                 run, i, obs_q[i].op, obs_q[i].a, obs_q[i].b, obs_q[i].c, obs_q[i].imm, obs_q[i].iv,
                                 exp_q[i].op, exp_q[i].a, exp_q[i].b, exp_q[i].c, exp_q[i].imm, exp_q[i].iv);
                    end
                end
            end
`ifdef ILLEGAL_TRAP_EN
            n_checks++;
            if (illegal_err !== merr) begin
                n_fail++; $display("FAIL rand%0d_err: got %0b want %0b", run, illegal_err, merr);
            end
`endif
        end
        z_flag = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_program();
        test_branch();
        test_back_pressure();
        test_pc_wrap();
        test_illegal();
        test_reset_mid_issue();
        test_random_programs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
